// File: rtl/ropuf_resp_gen_if.sv
// Handshake and data bundle for the RO-PUF response generator.
// The slave modport is the generator; the master modport is whoever requests
// evaluations and consumes responses.
interface ropuf_resp_gen_if #(
  parameter int COUNT_W = 4,
  parameter int N_BITS  = 8
);
  localparam int CNT_W = $clog2(N_BITS + 1);

  logic                        start;
  logic [N_BITS*COUNT_W-1:0]   count_a;
  logic [N_BITS*COUNT_W-1:0]   count_b;
  logic                        busy;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [N_BITS-1:0]           response;
  logic [N_BITS-1:0]           unstable;
  logic [CNT_W-1:0]            unstable_cnt;

  modport master (
    output start, count_a, count_b, resp_ready,
    input  busy, resp_valid, response, unstable, unstable_cnt
  );

  modport slave (
    input  start, count_a, count_b, resp_ready,
    output busy, resp_valid, response, unstable, unstable_cnt
  );
endinterface

// File: rtl/ropuf_resp_gen.sv
// Ring-oscillator PUF response generator: snapshots N_BITS counter pairs on
// start, compares one pair per cycle, flags pairs within MARGIN as unstable and
// offers the response word over a valid/ready handshake.
module ropuf_resp_gen #(
  parameter int COUNT_W = 4,
  parameter int N_BITS  = 8,
  parameter int MARGIN  = 0
) (
  input  logic               clk,
  input  logic               reset,
  ropuf_resp_gen_if.slave    bus
);

  localparam int CNT_W = $clog2(N_BITS + 1);
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [COUNT_W:0]   MARGIN_V = (COUNT_W + 1)'(MARGIN);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    HOLD
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_BITS*COUNT_W-1:0] snap_a_q, snap_a_d;
  logic [N_BITS*COUNT_W-1:0] snap_b_q, snap_b_d;
  logic [N_BITS-1:0]         response_q, response_d;
  logic [N_BITS-1:0]         unstable_q, unstable_d;
  logic [CNT_W-1:0]          ucnt_q, ucnt_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;

  logic [COUNT_W-1:0]        cur_a, cur_b;
  logic [COUNT_W:0]          diff;
  logic                      pair_gt;
  logic                      pair_unst;

  // Compare the snapshot pair selected by idx; the difference is taken in the
  // non-negative direction with one extra bit so it never wraps.
  always_comb begin
    cur_a     = snap_a_q[idx_q*COUNT_W +: COUNT_W];
    cur_b     = snap_b_q[idx_q*COUNT_W +: COUNT_W];
    pair_gt   = (cur_a > cur_b);
    if (pair_gt) begin
      diff = {1'b0, cur_a} - {1'b0, cur_b};
    end else begin
      diff = {1'b0, cur_b} - {1'b0, cur_a};
    end
    pair_unst = (diff <= MARGIN_V);
  end

  // Next-state and datapath updates for IDLE -> EVAL -> HOLD.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    response_d = response_q;
    unstable_d = unstable_q;
    ucnt_d     = ucnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_a_d   = bus.count_a;
          snap_b_d   = bus.count_b;
          response_d = '0;
          unstable_d = '0;
          ucnt_d     = '0;
          idx_d      = '0;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        response_d[idx_q] = pair_gt;
        unstable_d[idx_q] = pair_unst;
        ucnt_d            = ucnt_q + CNT_W'(pair_unst);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      HOLD: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == HOLD);
  end

  // State register with asynchronous active-low clear of all state and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
      response_q <= '0;
      unstable_q <= '0;
      ucnt_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
      response_q <= response_d;
      unstable_q <= unstable_d;
      ucnt_q     <= ucnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.resp_valid   = valid_q;
  assign bus.response     = response_q;
  assign bus.unstable     = unstable_q;
  assign bus.unstable_cnt = ucnt_q;

endmodule

// File: tb/tb_ropuf_resp_gen.sv
// Directed bench for ropuf_resp_gen with COUNT_W=4, N_BITS=4; one instance with
// MARGIN=1 and one with MARGIN=0 driven with identical stimulus.
module tb_ropuf_resp_gen;

  logic clk;
  logic rst_n;
  int   vec;
  int   miss;

  ropuf_resp_gen_if #(.COUNT_W(4), .N_BITS(4)) bus1 ();
  ropuf_resp_gen_if #(.COUNT_W(4), .N_BITS(4)) bus0 ();

  ropuf_resp_gen #(.COUNT_W(4), .N_BITS(4), .MARGIN(1)) u_m1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1.slave)
  );

  ropuf_resp_gen #(.COUNT_W(4), .N_BITS(4), .MARGIN(0)) u_m0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic [3:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic drive(input logic st, input logic rdy,
                       input logic [15:0] a, input logic [15:0] b);
    bus1.start = st;  bus0.start = st;
    bus1.resp_ready = rdy; bus0.resp_ready = rdy;
    bus1.count_a = a; bus0.count_a = a;
    bus1.count_b = b; bus0.count_b = b;
  endtask

  task automatic set_start(input logic st);
    bus1.start = st; bus0.start = st;
  endtask

  task automatic set_ready(input logic rdy);
    bus1.resp_ready = rdy; bus0.resp_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count cycles until resp_valid (bounded).
  task automatic start_and_wait(output int cyc);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    cyc = 0;
    while (!bus1.resp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, '0, '0);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({bus1.busy, bus1.resp_valid, bus1.response, bus1.unstable, bus1.unstable_cnt} !== '0) begin
      miss++;
      $display("FAIL reset_state: got busy=%b valid=%b resp=%b unst=%b cnt=%0d want all 0",
               bus1.busy, bus1.resp_valid, bus1.response, bus1.unstable, bus1.unstable_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    drive(1'b0, 1'b1, pk(9, 3, 7, 15), pk(4, 3, 8, 0));
    set_start(1'b1);
    tick();
    set_start(1'b0);
    vec++;
    if (bus1.busy !== 1'b1) begin
      miss++; $display("FAIL basic_busy: got %b want 1", bus1.busy);
    end
    cyc = 0;
    while (!bus1.resp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    vec++;
    if (cyc !== 4) begin
      miss++; $display("FAIL basic_latency: got %0d want 4", cyc);
    end
    vec++;
    if (bus1.response !== 4'b1001 || bus1.unstable !== 4'b0110 || bus1.unstable_cnt !== 3'd2) begin
      miss++;
      $display("FAIL basic_result: got resp=%b unst=%b cnt=%0d want 1001 0110 2",
               bus1.response, bus1.unstable, bus1.unstable_cnt);
    end
    tick();
    vec++;
    if (bus1.resp_valid !== 1'b0 || bus1.busy !== 1'b0) begin
      miss++; $display("FAIL basic_idle: got valid=%b busy=%b want 0 0", bus1.resp_valid, bus1.busy);
    end
    vec++;
    if (bus1.response !== 4'b1001) begin
      miss++; $display("FAIL basic_retain: got %b want 1001", bus1.response);
    end
  endtask

  task automatic test_snapshot();
    int cyc;
    drive(1'b1, 1'b1, pk(9, 3, 7, 15), pk(4, 3, 8, 0));
    tick();
    drive(1'b0, 1'b1, pk(0, 0, 0, 0), pk(15, 15, 15, 15));
    cyc = 0;
    while (!bus1.resp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    vec++;
    if (cyc !== 4 || bus1.response !== 4'b1001 || bus1.unstable !== 4'b0110) begin
      miss++;
      $display("FAIL snapshot: got cyc=%0d resp=%b unst=%b want 4 1001 0110",
               cyc, bus1.response, bus1.unstable);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    drive(1'b0, 1'b0, pk(9, 3, 7, 15), pk(4, 3, 8, 0));
    start_and_wait(cyc);
    vec++;
    if (cyc !== 4 || bus1.resp_valid !== 1'b1) begin
      miss++; $display("FAIL bp_first_valid: got cyc=%0d valid=%b want 4 1", cyc, bus1.resp_valid);
    end
    // New counts would give a different word if a start slipped through.
    drive(1'b0, 1'b0, pk(0, 15, 0, 15), pk(15, 0, 15, 0));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      set_start(i[0]);
      tick();
      if (bus1.resp_valid !== 1'b1 || bus1.response !== 4'b1001 ||
          bus1.unstable !== 4'b0110 || bus1.unstable_cnt !== 3'd2) bad++;
    end
    vec++;
    if (bad !== 0) begin
      miss++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    set_start(1'b0);
    set_ready(1'b1);
    tick();
    vec++;
    if (bus1.resp_valid !== 1'b0 || bus1.busy !== 1'b0) begin
      miss++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", bus1.resp_valid, bus1.busy);
    end
    start_and_wait(cyc);
    vec++;
    if (cyc !== 4 || bus1.response !== 4'b1010 || bus1.unstable !== 4'b0000) begin
      miss++;
      $display("FAIL bp_restart: got cyc=%0d resp=%b unst=%b want 4 1010 0000",
               cyc, bus1.response, bus1.unstable);
    end
    tick();
  endtask

  task automatic test_reset_mid_eval();
    int cyc;
    drive(1'b0, 1'b1, pk(9, 3, 7, 15), pk(4, 3, 8, 0));
    set_start(1'b1);
    tick();
    set_start(1'b0);
    tick();
    tick();
    vec++;
    if (bus1.busy !== 1'b1 || bus1.response[0] !== 1'b1) begin
      miss++; $display("FAIL mid_eval_pre: got busy=%b resp=%b want busy 1 bit0 1", bus1.busy, bus1.response);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({bus1.busy, bus1.resp_valid, bus1.response, bus1.unstable, bus1.unstable_cnt} !== '0) begin
      miss++;
      $display("FAIL mid_eval_reset: got busy=%b valid=%b resp=%b unst=%b cnt=%0d want all 0",
               bus1.busy, bus1.resp_valid, bus1.response, bus1.unstable, bus1.unstable_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, pk(1, 5, 2, 10), pk(3, 5, 0, 4));
    start_and_wait(cyc);
    vec++;
    if (cyc !== 4 || bus1.response !== 4'b1100 || bus1.unstable !== 4'b0010 || bus1.unstable_cnt !== 3'd1) begin
      miss++;
      $display("FAIL mid_eval_after: got cyc=%0d resp=%b unst=%b cnt=%0d want 4 1100 0010 1",
               cyc, bus1.response, bus1.unstable, bus1.unstable_cnt);
    end
    tick();
  endtask

  task automatic test_extremes();
    int cyc;
    drive(1'b0, 1'b1, pk(15, 0, 8, 8), pk(0, 15, 8, 9));
    start_and_wait(cyc);
    vec++;
    if (cyc !== 4 || bus1.response !== 4'b0001 || bus1.unstable !== 4'b1100 || bus1.unstable_cnt !== 3'd2) begin
      miss++;
      $display("FAIL extremes_m1: got cyc=%0d resp=%b unst=%b cnt=%0d want 4 0001 1100 2",
               cyc, bus1.response, bus1.unstable, bus1.unstable_cnt);
    end
    vec++;
    if (bus0.resp_valid !== 1'b1 || bus0.response !== 4'b0001 || bus0.unstable !== 4'b0100 || bus0.unstable_cnt !== 3'd1) begin
      miss++;
      $display("FAIL extremes_m0: got valid=%b resp=%b unst=%b cnt=%0d want 1 0001 0100 1",
               bus0.resp_valid, bus0.response, bus0.unstable, bus0.unstable_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int bad_busy;
    int bad_valid;
    logic exp_busy;
    logic exp_valid;
    drive(1'b1, 1'b1, pk(2, 2, 2, 2), pk(1, 1, 1, 1));
    bad_busy  = 0;
    bad_valid = 0;
    // After each accepting edge: four cycles in EVAL/HOLD-entry, one HOLD, one IDLE.
    for (int i = 0; i < 18; i++) begin
      tick();
      exp_busy  = ((i % 6) != 5);
      exp_valid = ((i % 6) == 4);
      if (bus1.busy !== exp_busy) bad_busy++;
      if (bus1.resp_valid !== exp_valid) bad_valid++;
    end
    vec++;
    if (bad_busy !== 0) begin
      miss++; $display("FAIL b2b_busy: got %0d bad cycles want 0", bad_busy);
    end
    vec++;
    if (bad_valid !== 0) begin
      miss++; $display("FAIL b2b_valid: got %0d bad cycles want 0", bad_valid);
    end
    vec++;
    if (bus1.response !== 4'b1111 || bus1.unstable !== 4'b1111 || bus1.unstable_cnt !== 3'd4) begin
      miss++;
      $display("FAIL b2b_result: got resp=%b unst=%b cnt=%0d want 1111 1111 4",
               bus1.response, bus1.unstable, bus1.unstable_cnt);
    end
    set_start(1'b0);
    tick();
  endtask

  initial begin
    vec  = 0;
    miss = 0;
    test_reset();
    test_basic();
    test_snapshot();
    test_backpressure();
    test_reset_mid_eval();
    test_extremes();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
